mc6809_cpu: RTL and testbench
=============================

Name: mc6809_cpu

Overview:
- Reduced MC6809-compatible 8-bit CPU core with a single synchronous bus master port: 16-bit address, 8-bit data in/out, active-high read/write strobes.
- Fetches the reset vector, then executes a load/store/increment/branch subset of the 6809 instruction set.
- Sits directly on the system memory, which latches read data on the rising edge of cpu_oe_o and writes on the rising edge of cpu_we_o.

Parameters:
- RESET_VECTOR, 16'hFFFE, address of the reset vector high byte; the low byte is at +1.
- DP_RESET, 8'h00, direct-page register value after reset.

Ports:
- cpu_clk  in  1  sole clock; all state changes on rising edge.
- cpu_reset  in  1  synchronous, active-high reset.
- cpu_we_o  out  1  write strobe, active high.
- cpu_oe_o  out  1  read strobe, active high.
- cpu_addr_o  out  16  bus address.
- cpu_data_i  in  8  read data.
- cpu_data_o  out  8  write data.

Behaviour:
- Registers: A, B (8b), DP (8b, constant DP_RESET), PC (16b), CC flags N, Z, V, C. X/Y/U/S and interrupts are out of scope.
- Reset values: A=B=0, CC=0, PC=0, cpu_oe_o=0, cpu_we_o=0, cpu_addr_o=RESET_VECTOR, cpu_data_o=0.
- Reset taken mid-operation aborts the access immediately and restarts the vector fetch.
- Bus access is always 2 clocks:
  - Phase A: cpu_addr_o (and cpu_data_o for writes) driven, both strobes 0.
  - Phase B: address and data held; exactly one strobe = 1.
  - Read data is captured from cpu_data_i on the clock edge ending phase B.
  - Strobes are never high in consecutive clocks, so every access produces a fresh rising edge.
- State machine: VEC_HI, VEC_LO, FETCH_OP, FETCH_B1, FETCH_B2, MEM_RD, MEM_WR; each state is one 2-clock bus access.
  - VEC_HI -> VEC_LO; after VEC_LO, PC = {hi, lo} and the next state is FETCH_OP.
  - Every opcode or operand fetch reads at PC, then PC increments by 1.
- Effective addresses:
  - Direct: EA = {DP, byte1}.
  - Extended: EA = {byte1, byte2}.
- Supported opcodes (hex), with clock counts:
  - LDA 86/96/B6, LDB C6/D6/F6: imm 4, dir 6, ext 8 clocks. Flags: N, Z from value; V=0; C unchanged.
  - STA 97/B7, STB D7/F7: write register at EA. dir 6, ext 8 clocks. Flags as for load.
  - INCA 4C, INCB 5C: 2 clocks. V=1 iff operand was 7F; N, Z from result; C unchanged; 8-bit wrap FF->00.
  - DECA 4A, DECB 5A: 2 clocks. V=1 iff operand was 80; wrap 00->FF.
  - CLRA 4F, CLRB 5F: 2 clocks. N=0, Z=1, V=0, C=0.
  - NOP 12: 2 clocks.
  - Short branches 20-2F: standard 6809 conditions, e.g. BRA always, BNE Z=0, BEQ Z=1. Offset is a signed 8-bit value added to the PC that points after the offset byte; 16-bit wrap. 4 clocks whether or not the branch is taken.
- Any other opcode: executed as a 1-byte NOP (2 clocks); no trap.
- Register and flag updates take effect on the edge that captures the last needed byte.

Decomposition:
- Shared package mc6809_pkg: opcode constants, state enum, CC bit indices, branch-condition encoding.
- One natural sub-module, mc6809_alu8: pass/inc/dec/clr, producing result and N/Z/V.
- Bus sequencing and decode stay in mc6809_cpu.

Test Plan:
- Reset held 3 clocks, memory FFFE=10, FFFF=00 -> reads at FFFE then FFFF, each with oe high in phase B only; next read address is 1000.
- Program at 1000: 86 02 C6 00 97 00 D7 01 B6 00 00 26 F7 -> writes 0000=02, 0001=00; read of 0000 yields A=02, Z=0; BNE goes to 1004; the write pair repeats forever.
- Program 86 7F 4C -> A=80, N=1, V=1, Z=0; then 4A -> A=7F, V=1, N=0.
- Program C6 FF 5C -> B=00, Z=1, N=0; then 27 FE (BEQ *) loops at the same address; 26 02 is not taken and execution falls through.
- Program F7 12 34 (STB ext) with B=A5 -> single write, address 1234, data A5, we high exactly one clock with data and address stable in both phases.
- Assert reset during phase B of a write -> we drops the next clock; the next access is the read of FFFE.

Source files
------------

// File: rtl/mc6809_pkg.sv
// Shared definitions for the reduced 6809 core: bus states, opcode map,
// flag positions, branch-condition encoding and the opcode decoder.
package mc6809_pkg;

  typedef enum logic [2:0] {
    VEC_HI, VEC_LO, FETCH_OP, FETCH_B1, FETCH_B2, MEM_RD, MEM_WR
  } state_e;

  typedef enum logic [1:0] {ALU_PASS, ALU_INC, ALU_DEC, ALU_CLR} alu_op_e;
  typedef enum logic [2:0] {K_NOP, K_INH, K_LD, K_ST, K_BR} kind_e;
  typedef enum logic [1:0] {M_INH, M_IMM, M_DIR, M_EXT} mode_e;

  typedef struct packed {
    kind_e   kind;
    mode_e   mode;
    logic    reg_b;
    alu_op_e alu;
  } dec_t;

  localparam int CC_C = 0;
  localparam int CC_V = 1;
  localparam int CC_Z = 2;
  localparam int CC_N = 3;

  localparam logic [7:0] OP_LDA_IMM = 8'h86, OP_LDA_DIR = 8'h96, OP_LDA_EXT = 8'hB6;
  localparam logic [7:0] OP_LDB_IMM = 8'hC6, OP_LDB_DIR = 8'hD6, OP_LDB_EXT = 8'hF6;
  localparam logic [7:0] OP_STA_DIR = 8'h97, OP_STA_EXT = 8'hB7;
  localparam logic [7:0] OP_STB_DIR = 8'hD7, OP_STB_EXT = 8'hF7;
  localparam logic [7:0] OP_INCA = 8'h4C, OP_INCB = 8'h5C;
  localparam logic [7:0] OP_DECA = 8'h4A, OP_DECB = 8'h5A;
  localparam logic [7:0] OP_CLRA = 8'h4F, OP_CLRB = 8'h5F;
  localparam logic [7:0] OP_NOP  = 8'h12;

  // Opcode bits [3:1] pick the base test; bit 0 inverts it (BRA/BRN, BNE/BEQ, ...).
  typedef enum logic [2:0] {
    BC_ALWAYS, BC_HI, BC_CC, BC_NE, BC_VC, BC_PL, BC_GE, BC_GT
  } bcond_e;

  function automatic dec_t decode(input logic [7:0] op);
    dec_t d;
    d.kind  = K_NOP;
    d.mode  = M_INH;
    d.alu   = ALU_PASS;
    d.reg_b = (op[7:4] == 4'h5) || (op[7:6] == 2'b11);
    case (op)
      OP_LDA_IMM, OP_LDB_IMM: begin d.kind = K_LD; d.mode = M_IMM; end
      OP_LDA_DIR, OP_LDB_DIR: begin d.kind = K_LD; d.mode = M_DIR; end
      OP_LDA_EXT, OP_LDB_EXT: begin d.kind = K_LD; d.mode = M_EXT; end
      OP_STA_DIR, OP_STB_DIR: begin d.kind = K_ST; d.mode = M_DIR; end
      OP_STA_EXT, OP_STB_EXT: begin d.kind = K_ST; d.mode = M_EXT; end
      OP_INCA, OP_INCB:       begin d.kind = K_INH; d.alu = ALU_INC; end
      OP_DECA, OP_DECB:       begin d.kind = K_INH; d.alu = ALU_DEC; end
      OP_CLRA, OP_CLRB:       begin d.kind = K_INH; d.alu = ALU_CLR; end
      OP_NOP:                 d.kind = K_NOP;
      default: begin
        if (op[7:4] == 4'h2) begin
          d.kind = K_BR;
          d.mode = M_IMM;
        end
      end
    endcase
    return d;
  endfunction

  function automatic logic branch_taken(input logic [3:0] cond, input logic [3:0] cc);
    logic n, z, v, c, t;
    n = cc[CC_N];
    z = cc[CC_Z];
    v = cc[CC_V];
    c = cc[CC_C];
    case (bcond_e'(cond[3:1]))
      BC_ALWAYS: t = 1'b1;
      BC_HI:     t = !(c | z);
      BC_CC:     t = !c;
      BC_NE:     t = !z;
      BC_VC:     t = !v;
      BC_PL:     t = !n;
      BC_GE:     t = !(n ^ v);
      BC_GT:     t = !(z | (n ^ v));
      default:   t = 1'b1;
    endcase
    return t ^ cond[0];
  endfunction

endpackage

// File: rtl/mc6809_alu8.sv
// 8-bit accumulator ALU: pass-through (loads/stores), increment, decrement, clear.
module mc6809_alu8
  import mc6809_pkg::*;
(
  input  alu_op_e    op_i,
  input  logic [7:0] a_i,
  output logic [7:0] res_o,
  output logic       n_o,
  output logic       z_o,
  output logic       v_o
);

  always_comb begin
    res_o = a_i;
    v_o   = 1'b0;
    case (op_i)
      ALU_INC: begin res_o = a_i + 8'd1; v_o = (a_i == 8'h7F); end
      ALU_DEC: begin res_o = a_i - 8'd1; v_o = (a_i == 8'h80); end
      ALU_CLR: res_o = 8'h00;
      default: ;
    endcase
    n_o = res_o[7];
    z_o = (res_o == 8'h00);
  end

endmodule

// File: rtl/mc6809_cpu.sv
// Reduced 6809 core: every state is one two-clock bus access (address phase,
// then strobe phase); results land on the edge that ends the strobe phase.
module mc6809_cpu
  import mc6809_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
  parameter logic [7:0]  DP_RESET     = 8'h00
) (
  input  logic        cpu_clk,
  input  logic        cpu_reset,
  output logic        cpu_we_o,
  output logic        cpu_oe_o,
  output logic [15:0] cpu_addr_o,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o
);

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [15:0] addr_q, addr_d, pc_q, pc_d;
  logic        oe_q, oe_d, we_q, we_d;
  logic [7:0]  dout_q, dout_d, a_q, a_d, b_q, b_d, op_q, op_d, b1_q, b1_d;
  logic [3:0]  cc_q, cc_d;

  dec_t        dec;
  alu_op_e     alu_op;
  logic [7:0]  alu_in, alu_res, reg_val;
  logic        alu_n, alu_z, alu_v, upd_reg, upd_flags;
  logic [15:0] ea;

  // While fetching the opcode, decode the byte arriving on the bus; afterwards the latched one.
  assign dec     = decode((state_q == FETCH_OP) ? cpu_data_i : op_q);
  assign reg_val = dec.reg_b ? b_q : a_q;
  assign ea      = (state_q == FETCH_B2) ? {b1_q, cpu_data_i} : {DP_RESET, cpu_data_i};

  mc6809_alu8 u_alu (
    .op_i  (alu_op),
    .a_i   (alu_in),
    .res_o (alu_res),
    .n_o   (alu_n),
    .z_o   (alu_z),
    .v_o   (alu_v)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state_q <= VEC_HI;
      phase_q <= 1'b0;
      addr_q  <= RESET_VECTOR;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      dout_q  <= 8'h00;
      pc_q    <= 16'h0000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cc_q    <= 4'h0;
      op_q    <= 8'h00;
      b1_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cc_q    <= cc_d;
      op_q    <= op_d;
      b1_q    <= b1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (phase_q) begin
      case (state_q)
        VEC_HI:   state_d = VEC_LO;
        VEC_LO:   state_d = FETCH_OP;
        FETCH_OP: state_d = (dec.mode == M_INH) ? FETCH_OP : FETCH_B1;
        FETCH_B1: begin
          if (dec.mode == M_EXT)      state_d = FETCH_B2;
          else if (dec.mode != M_DIR) state_d = FETCH_OP;
          else if (dec.kind == K_ST)  state_d = MEM_WR;
          else                        state_d = MEM_RD;
        end
        FETCH_B2: state_d = (dec.kind == K_ST) ? MEM_WR : MEM_RD;
        default:  state_d = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    alu_op = ALU_PASS;
    alu_in = cpu_data_i;
    if (state_q == FETCH_OP) begin
      alu_op = dec.alu;
      alu_in = reg_val;
    end else if (state_q == MEM_WR) begin
      alu_in = reg_val;
    end
  end

  always_comb begin
    phase_d   = ~phase_q;
    addr_d    = addr_q;
    oe_d      = 1'b0;
    we_d      = 1'b0;
    dout_d    = dout_q;
    pc_d      = pc_q;
    a_d       = a_q;
    b_d       = b_q;
    cc_d      = cc_q;
    op_d      = op_q;
    b1_d      = b1_q;
    upd_reg   = 1'b0;
    upd_flags = 1'b0;
    if (!phase_q) begin
      oe_d = (state_q != MEM_WR);
      we_d = (state_q == MEM_WR);
    end else begin
      case (state_q)
        VEC_HI: b1_d = cpu_data_i;
        VEC_LO: pc_d = {b1_q, cpu_data_i};
        FETCH_OP: begin
          op_d      = cpu_data_i;
          pc_d      = pc_q + 16'd1;
          upd_reg   = (dec.kind == K_INH);
          upd_flags = (dec.kind == K_INH);
        end
        FETCH_B1: begin
          b1_d      = cpu_data_i;
          pc_d      = pc_q + 16'd1;
          upd_reg   = (dec.kind == K_LD) && (dec.mode == M_IMM);
          upd_flags = upd_reg;
          // Offset is relative to the address just past the offset byte.
          if (dec.kind == K_BR && branch_taken(op_q[3:0], cc_q))
            pc_d = pc_q + 16'd1 + {{8{cpu_data_i[7]}}, cpu_data_i};
        end
        FETCH_B2: pc_d = pc_q + 16'd1;
        MEM_RD: begin
          upd_reg   = 1'b1;
          upd_flags = 1'b1;
        end
        MEM_WR:  upd_flags = 1'b1;
        default: ;
      endcase
      case (state_d)
        VEC_LO:         addr_d = RESET_VECTOR + 16'd1;
        MEM_RD, MEM_WR: addr_d = ea;
        default:        addr_d = pc_d;
      endcase
      if (state_d == MEM_WR) dout_d = reg_val;
    end
    if (upd_reg) begin
      if (dec.reg_b) b_d = alu_res;
      else           a_d = alu_res;
    end
    if (upd_flags) begin
      cc_d[CC_N] = alu_n;
      cc_d[CC_Z] = alu_z;
      cc_d[CC_V] = alu_v;
      if (alu_op == ALU_CLR) cc_d[CC_C] = 1'b0;
    end
  end

  assign cpu_addr_o = addr_q;
  assign cpu_oe_o   = oe_q;
  assign cpu_we_o   = we_q;
  assign cpu_data_o = dout_q;

endmodule

// File: tb/tb_mc6809_cpu.sv
// Bench for mc6809_cpu: instruction-level model predicts every bus access,
// a per-cycle monitor checks strobes/addresses/data and access spacing.
module tb_mc6809_cpu;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset = 1'b1;
  logic        cpu_we_o, cpu_oe_o;
  logic [15:0] cpu_addr_o;
  logic [7:0]  cpu_data_i, cpu_data_o;

  always #5 cpu_clk = ~cpu_clk;

  mc6809_cpu dut (
    .cpu_clk    (cpu_clk),
    .cpu_reset  (cpu_reset),
    .cpu_we_o   (cpu_we_o),
    .cpu_oe_o   (cpu_oe_o),
    .cpu_addr_o (cpu_addr_o),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // System memory: latch on rising oe, write on rising we.
  logic [7:0] mem [0:65535];
  logic [7:0] rd_data = 8'h00;
  int wr_count = 0;
  int wr_1234 = 0;
  assign cpu_data_i = rd_data;
  always @(posedge cpu_oe_o) rd_data = mem[cpu_addr_o];
  always @(posedge cpu_we_o) begin
    mem[cpu_addr_o] = cpu_data_o;
    wr_count++;
    if (cpu_addr_o == 16'h1234) wr_1234++;
  end

  // Behavioural model: executes whole instructions, queueing the accesses they make.
  typedef struct packed { logic w; logic [15:0] a; logic [7:0] d; } acc_t;
  acc_t        expq[$];
  logic [7:0]  mmem [0:65535];
  logic [7:0]  ma, mb;
  logic [15:0] mpc;
  logic        mn, mz, mv, mc;

  task automatic m_rd(input logic [15:0] a, output logic [7:0] d);
    acc_t e;
    e.w = 1'b0; e.a = a; e.d = 8'h00;
    expq.push_back(e);
    d = mmem[a];
  endtask

  task automatic m_wr(input logic [15:0] a, input logic [7:0] d);
    acc_t e;
    e.w = 1'b1; e.a = a; e.d = d;
    expq.push_back(e);
    mmem[a] = d;
  endtask

  task automatic m_load(input logic to_b, input logic [7:0] v);
    if (to_b) mb = v; else ma = v;
    mn = v[7]; mz = (v == 8'h00); mv = 1'b0;
  endtask

  task automatic m_store(input logic [15:0] a, input logic [7:0] v);
    m_wr(a, v);
    mn = v[7]; mz = (v == 8'h00); mv = 1'b0;
  endtask

  task automatic m_step();
    logic [7:0] op, b1, b2, v;
    logic take;
    m_rd(mpc, op); mpc++;
    case (op)
      8'h86, 8'hC6: begin m_rd(mpc, v); mpc++; m_load(op == 8'hC6, v); end
      8'h96, 8'hD6: begin m_rd(mpc, b1); mpc++; m_rd({8'h00, b1}, v); m_load(op == 8'hD6, v); end
      8'hB6, 8'hF6: begin
        m_rd(mpc, b1); mpc++; m_rd(mpc, b2); mpc++;
        m_rd({b1, b2}, v); m_load(op == 8'hF6, v);
      end
      8'h97: begin m_rd(mpc, b1); mpc++; m_store({8'h00, b1}, ma); end
      8'hD7: begin m_rd(mpc, b1); mpc++; m_store({8'h00, b1}, mb); end
      8'hB7: begin m_rd(mpc, b1); mpc++; m_rd(mpc, b2); mpc++; m_store({b1, b2}, ma); end
      8'hF7: begin m_rd(mpc, b1); mpc++; m_rd(mpc, b2); mpc++; m_store({b1, b2}, mb); end
      8'h4C: begin mv = (ma == 8'h7F); ma = ma + 8'd1; mn = ma[7]; mz = (ma == 0); end
      8'h5C: begin mv = (mb == 8'h7F); mb = mb + 8'd1; mn = mb[7]; mz = (mb == 0); end
      8'h4A: begin mv = (ma == 8'h80); ma = ma - 8'd1; mn = ma[7]; mz = (ma == 0); end
      8'h5A: begin mv = (mb == 8'h80); mb = mb - 8'd1; mn = mb[7]; mz = (mb == 0); end
      8'h4F: begin ma = 8'h00; mn = 0; mz = 1; mv = 0; mc = 0; end
      8'h5F: begin mb = 8'h00; mn = 0; mz = 1; mv = 0; mc = 0; end
      default: begin
        if (op >= 8'h20 && op <= 8'h2F) begin
          m_rd(mpc, v); mpc++;
          case (op[3:0])
            4'h0: take = 1'b1;             4'h1: take = 1'b0;
            4'h2: take = !mc && !mz;       4'h3: take = mc || mz;
            4'h4: take = !mc;              4'h5: take = mc;
            4'h6: take = !mz;              4'h7: take = mz;
            4'h8: take = !mv;              4'h9: take = mv;
            4'hA: take = !mn;              4'hB: take = mn;
            4'hC: take = (mn == mv);       4'hD: take = (mn != mv);
            4'hE: take = !mz && (mn == mv);
            default: take = mz || (mn != mv);
          endcase
          if (take) mpc = mpc + {{8{v[7]}}, v};
        end
      end
    endcase
  endtask

  task automatic m_reset();
    logic [7:0] hi, lo;
    expq.delete();
    ma = 0; mb = 0; mn = 0; mz = 0; mv = 0; mc = 0;
    m_rd(16'hFFFE, hi);
    m_rd(16'hFFFF, lo);
    mpc = {hi, lo};
  endtask

  // Per-cycle monitor.
  logic        prev_oe = 0, prev_we = 0;
  logic [15:0] prev_addr = 0;
  logic [7:0]  prev_dout = 0;
  int          gap = 0;
  bit          seen = 0;
  logic [15:0] strobe_log[$];

  always @(negedge cpu_clk) begin
    acc_t e;
    if (cpu_reset) begin
      seen = 0;
      gap  = 0;
    end else begin
      gap++;
      if (cpu_oe_o || cpu_we_o) begin
        if (expq.size() == 0) m_step();
        e = expq.pop_front();
        $display("bus %s addr=%h data=%h", e.w ? "W" : "R", cpu_addr_o, e.w ? cpu_data_o : rd_data);
        chk("strobe_excl", {31'd0, cpu_oe_o & cpu_we_o}, 32'd0);
        chk("phaseA_idle", {30'd0, prev_oe, prev_we}, 32'd0);
        chk("phaseA_addr", {16'd0, prev_addr}, {16'd0, e.a});
        chk("access_rw", {31'd0, cpu_we_o}, {31'd0, e.w});
        chk("access_addr", {16'd0, cpu_addr_o}, {16'd0, e.a});
        if (e.w) begin
          chk("wdata_phaseA", {24'd0, prev_dout}, {24'd0, e.d});
          chk("wdata_phaseB", {24'd0, cpu_data_o}, {24'd0, e.d});
        end
        if (seen) chk("access_spacing", gap, 2);
        seen = 1;
        gap  = 0;
        strobe_log.push_back(cpu_addr_o);
      end
    end
    prev_oe   = cpu_oe_o;
    prev_we   = cpu_we_o;
    prev_addr = cpu_addr_o;
    prev_dout = cpu_data_o;
  end

  logic [7:0] prog[$];

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a]  = d;
    mmem[a] = d;
  endtask

  // Reset for 3 clocks, load vector + program at 1000 into memory and model.
  task automatic start_prog();
    @(posedge cpu_clk); #1 cpu_reset = 1'b1;
    @(posedge cpu_clk); #1;
    for (int i = 0; i < 65536; i++) poke(i[15:0], 8'h00);
    poke(16'hFFFE, 8'h10);
    poke(16'hFFFF, 8'h00);
    for (int i = 0; i < prog.size(); i++) poke(16'h1000 + i[15:0], prog[i]);
    m_reset();
    strobe_log.delete();
    wr_count = 0;
    wr_1234  = 0;
    repeat (2) @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    logic found;
    // Scenario 1: load/store/branch loop, plus reset-state outputs.
    prog = '{8'h86, 8'h02, 8'hC6, 8'h00, 8'h97, 8'h00, 8'hD7, 8'h01,
             8'hB6, 8'h00, 8'h00, 8'h26, 8'hF7};
    start_prog();
    poke(16'h0000, 8'hFF);
    poke(16'h0001, 8'hFF);
    chk("reset_addr", {16'd0, cpu_addr_o}, 32'h0000FFFE);
    chk("reset_strobes", {30'd0, cpu_oe_o, cpu_we_o}, 32'd0);
    chk("reset_dout", {24'd0, cpu_data_o}, 32'd0);
    cpu_reset = 1'b0;
    repeat (100) @(posedge cpu_clk);
    #1;
    chk("s1_strobe_count", {31'd0, strobe_log.size() >= 3}, 32'd1);
    chk("s1_vec_hi", {16'd0, strobe_log[0]}, 32'h0000FFFE);
    chk("s1_vec_lo", {16'd0, strobe_log[1]}, 32'h0000FFFF);
    chk("s1_first_op", {16'd0, strobe_log[2]}, 32'h00001000);
    chk("s1_mem0", {24'd0, mem[0]}, 32'h02);
    chk("s1_mem1", {24'd0, mem[1]}, 32'h00);
    chk("s1_loop_repeats", {31'd0, wr_count >= 4}, 32'd1);
    chk("s1_model_a", {24'd0, ma}, 32'h02);

    // Scenario 2: INCA 7F->80 sets V, DECA 80->7F sets V (observed via BVS).
    prog = '{8'h86, 8'h7F, 8'h4C, 8'h29, 8'h02, 8'h20, 8'hFE, 8'h97, 8'h10,
             8'h4A, 8'h29, 8'h02, 8'h20, 8'hFE, 8'h97, 8'h11, 8'h20, 8'hFE};
    start_prog();
    cpu_reset = 1'b0;
    repeat (80) @(posedge cpu_clk);
    #1;
    chk("s2_inca_result", {24'd0, mem[16'h0010]}, 32'h80);
    chk("s2_deca_result", {24'd0, mem[16'h0011]}, 32'h7F);
    chk("s2_model_a", {24'd0, ma}, 32'h7F);

    // Scenario 3: INCB FF->00, BNE not taken, STB, BEQ * spins.
    prog = '{8'hC6, 8'hFF, 8'h5C, 8'h26, 8'h02, 8'hD7, 8'h20, 8'h27, 8'hFE};
    start_prog();
    poke(16'h0020, 8'h55);
    cpu_reset = 1'b0;
    repeat (60) @(posedge cpu_clk);
    #1;
    chk("s3_stb_zero", {24'd0, mem[16'h0020]}, 32'h00);
    chk("s3_spin_addr", {31'd0, strobe_log[$] == 16'h1007 || strobe_log[$] == 16'h1008}, 32'd1);
    chk("s3_model_b", {24'd0, mb}, 32'h00);

    // Scenario 4: STB extended, CLRA, undefined opcode, NOP, STA direct.
    prog = '{8'hC6, 8'hA5, 8'hF7, 8'h12, 8'h34, 8'h4F, 8'h01, 8'h12,
             8'h97, 8'h30, 8'h27, 8'hFE};
    start_prog();
    poke(16'h0030, 8'h77);
    cpu_reset = 1'b0;
    repeat (80) @(posedge cpu_clk);
    #1;
    chk("s4_ext_data", {24'd0, mem[16'h1234]}, 32'hA5);
    chk("s4_ext_single", wr_1234, 1);
    chk("s4_total_writes", wr_count, 2);
    chk("s4_clra_store", {24'd0, mem[16'h0030]}, 32'h00);

    // Scenario 5: reset during the strobe phase of a write.
    prog = '{8'h86, 8'h02, 8'hC6, 8'h00, 8'h97, 8'h00, 8'hD7, 8'h01,
             8'hB6, 8'h00, 8'h00, 8'h26, 8'hF7};
    start_prog();
    cpu_reset = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge cpu_clk);
      if (cpu_we_o) found = 1'b1;
    end
    chk("s5_write_seen", {31'd0, found}, 32'd1);
    #1 cpu_reset = 1'b1;
    @(posedge cpu_clk); #1;
    chk("s5_we_dropped", {31'd0, cpu_we_o}, 32'd0);
    chk("s5_oe_low", {31'd0, cpu_oe_o}, 32'd0);
    chk("s5_addr_vector", {16'd0, cpu_addr_o}, 32'h0000FFFE);
    @(posedge cpu_clk); #1;
    m_reset();
    strobe_log.delete();
    @(posedge cpu_clk); #1;
    cpu_reset = 1'b0;
    repeat (20) @(posedge cpu_clk);
    #1;
    chk("s5_refetch_vector", {16'd0, strobe_log[0]}, 32'h0000FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
